// File: rtl/frame_ctrl_pkg.sv
// Shared definitions for the frame controller: write FSM state type,
// default raster timing and a small window-decode helper.
package frame_ctrl_pkg;

    // Host write handshake states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } wr_state_e;

    // Default raster timing (columns / lines, blanking included)
    localparam int H_L_DEF      = 896;
    localparam int V_L_DEF      = 795;
    localparam int WIDTH_DEF    = 768;
    localparam int HEIGHT_DEF   = 683;
    localparam int HS_START_DEF = 792;
    localparam int HS_LEN_DEF   = 64;
    localparam int VS_START_DEF = 684;
    localparam int VS_LEN_DEF   = 3;

    // Pixel colour width (one bit each of R, G, B)
    localparam int RGB_W = 3;

    // True when start <= val < start + len
    function automatic logic in_window(input int unsigned val,
                                       input int unsigned start,
                                       input int unsigned len);
        return (val >= start) && (val < start + len);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Raster scan counter: column/line position, active-region select,
// active-low sync windows and a frame-wrap pulse. Also reports whether
// the position one pixel ahead is active so writers can avoid it.
module scan_counter
    import frame_ctrl_pkg::*;
#(
    parameter int  H_L      = H_L_DEF,
    parameter int  V_L      = V_L_DEF,
    parameter int  WIDTH    = WIDTH_DEF,
    parameter int  HEIGHT   = HEIGHT_DEF,
    parameter int  HS_START = HS_START_DEF,
    parameter int  HS_LEN   = HS_LEN_DEF,
    parameter int  VS_START = VS_START_DEF,
    parameter int  VS_LEN   = VS_LEN_DEF,
    localparam int HW       = $clog2(H_L),
    localparam int VW       = $clog2(V_L)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          pix_en_i,
    output logic [HW-1:0] h_count_o,
    output logic [VW-1:0] v_count_o,
    output logic          sel_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          frame_start_o,
    output logic          next_active_o
);

    logic [HW-1:0] h_q, h_d, h_nxt;
    logic [VW-1:0] v_q, v_d, v_nxt;
    logic          fs_q, fs_d;
    logic          h_last, v_last;

    assign h_last = (32'(h_q) == H_L - 1);
    assign v_last = (32'(v_q) == V_L - 1);

    // Position one pixel ahead, independent of the enable
    always_comb begin
        h_nxt = h_last ? '0 : h_q + HW'(1);
        v_nxt = v_q;
        if (h_last) begin
            v_nxt = v_last ? '0 : v_q + VW'(1);
        end
    end

    // Advance only on pixel enable; flag the edge that wraps the frame
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        fs_d = 1'b0;
        if (pix_en_i) begin
            h_d  = h_nxt;
            v_d  = v_nxt;
            fs_d = h_last && v_last;
        end
    end

    // Counter and frame-pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q  <= '0;
            v_q  <= '0;
            fs_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            fs_q <= fs_d;
        end
    end

    assign h_count_o     = h_q;
    assign v_count_o     = v_q;
    assign frame_start_o = fs_q;
    assign sel_o         = (32'(h_q) < WIDTH) && (32'(v_q) < HEIGHT);
    assign next_active_o = (32'(h_nxt) < WIDTH) && (32'(v_nxt) < HEIGHT);
    assign hsync_o       = !in_window(32'(h_q), HS_START, HS_LEN);
    assign vsync_o       = !in_window(32'(v_q), VS_START, VS_LEN);

endmodule

// File: rtl/frame_ctrl.sv
// Frame controller top: raster timing from scan_counter plus a host write
// FSM that places single-pixel writes into blanking so they never collide
// with an active pixel read. Optional macro FRAME_CTRL_BOUNDS_CHK_EN rejects
// writes outside the active area (WR_ACK with WR_ERR, no RAM write).
module frame_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int  H_L      = H_L_DEF,
    parameter int  V_L      = V_L_DEF,
    parameter int  WIDTH    = WIDTH_DEF,
    parameter int  HEIGHT   = HEIGHT_DEF,
    parameter int  HS_START = HS_START_DEF,
    parameter int  HS_LEN   = HS_LEN_DEF,
    parameter int  VS_START = VS_START_DEF,
    parameter int  VS_LEN   = VS_LEN_DEF,
    localparam int HW       = $clog2(H_L),
    localparam int VW       = $clog2(V_L)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PIX_EN,
    output logic [HW-1:0]    H_count,
    output logic [VW-1:0]    V_count,
    output logic             SEL,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             FRAME_START,
    input  logic             WR_REQ,
    input  logic [HW-1:0]    WR_X,
    input  logic [VW-1:0]    WR_Y,
    input  logic [RGB_W-1:0] WR_DATA,
    output logic             WR_ACK,
    output logic             WR_ERR,
    output logic             RAM_WE,
    output logic [HW-1:0]    RAM_WX,
    output logic [VW-1:0]    RAM_WY,
    output logic [RGB_W-1:0] RAM_WD
);

    wr_state_e        state_q, state_d;
    logic [HW-1:0]    wx_q, wx_d;
    logic [VW-1:0]    wy_q, wy_d;
    logic [RGB_W-1:0] wd_q, wd_d;
    logic             next_active;
    logic             blank_ok;
`ifdef FRAME_CTRL_BOUNDS_CHK_EN
    logic             err_q, err_d;
    logic             oob;
`endif

    scan_counter #(
        .H_L      (H_L),
        .V_L      (V_L),
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .HS_START (HS_START),
        .HS_LEN   (HS_LEN),
        .VS_START (VS_START),
        .VS_LEN   (VS_LEN)
    ) u_scan (
        .clk_i         (CLK),
        .rst_i         (RST),
        .pix_en_i      (PIX_EN),
        .h_count_o     (H_count),
        .v_count_o     (V_count),
        .sel_o         (SEL),
        .hsync_o       (HSYNC),
        .vsync_o       (VSYNC),
        .frame_start_o (FRAME_START),
        .next_active_o (next_active)
    );

    // Safe to write now and in the following cycle: neither is an active pixel
    assign blank_ok = !SEL && !(PIX_EN && next_active);

`ifdef FRAME_CTRL_BOUNDS_CHK_EN
    assign oob = (32'(WR_X) >= WIDTH) || (32'(WR_Y) >= HEIGHT);
`endif

    // Write FSM next state; the write port is latched on entry to WRITE
    always_comb begin
        state_d = state_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        wd_d    = wd_q;
`ifdef FRAME_CTRL_BOUNDS_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef FRAME_CTRL_BOUNDS_CHK_EN
                err_d = 1'b0;
`endif
                if (WR_REQ) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!WR_REQ) begin
                    state_d = ST_IDLE;
`ifdef FRAME_CTRL_BOUNDS_CHK_EN
                end else if (oob) begin
                    state_d = ST_ACK;
                    err_d   = 1'b1;
`endif
                end else if (blank_ok) begin
                    state_d = ST_WRITE;
                    wx_d    = WR_X;
                    wy_d    = WR_Y;
                    wd_d    = WR_DATA;
                end
            end
            ST_WRITE: state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM and write-port registers; reset aborts any transaction in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wx_q    <= '0;
            wy_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wd_q    <= wd_d;
        end
    end

`ifdef FRAME_CTRL_BOUNDS_CHK_EN
    // Rejection flag travels with the transaction into ACK
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign WR_ERR = (state_q == ST_ACK) && err_q;
`else
    assign WR_ERR = 1'b0;
`endif

    assign RAM_WE = (state_q == ST_WRITE);
    assign WR_ACK = (state_q == ST_ACK);
    assign RAM_WX = wx_q;
    assign RAM_WY = wy_q;
    assign RAM_WD = wd_q;

endmodule

// File: tb/tb_frame_ctrl.sv
// Scoreboard bench for frame_ctrl on a reduced raster. Stimulus pushes the
// expected RAM writes / acks; a negedge monitor checks them and the raster
// outputs against a position-based reference model.
module tb_frame_ctrl;

    localparam int H_L = 40;
    localparam int V_L = 20;
    localparam int WID = 30;
    localparam int HGT = 15;
    localparam int HSS = 32;
    localparam int HSN = 4;
    localparam int VSS = 16;
    localparam int VSN = 2;
    localparam int N   = H_L * V_L;
    localparam int HW  = $clog2(H_L);
    localparam int VW  = $clog2(V_L);
`ifdef FRAME_CTRL_BOUNDS_CHK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef struct {
        int cyc;
        int x;
        int y;
        int d;
        int err;
    } exp_t;

    logic          CLK, RST, PIX_EN;
    logic [HW-1:0] H_count, WR_X, RAM_WX;
    logic [VW-1:0] V_count, WR_Y, RAM_WY;
    logic [2:0]    WR_DATA, RAM_WD;
    logic          SEL, HSYNC, VSYNC, FRAME_START;
    logic          WR_REQ, WR_ACK, WR_ERR, RAM_WE;

    frame_ctrl #(
        .H_L(H_L), .V_L(V_L), .WIDTH(WID), .HEIGHT(HGT),
        .HS_START(HSS), .HS_LEN(HSN), .VS_START(VSS), .VS_LEN(VSN)
    ) dut (
        .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN),
        .H_count(H_count), .V_count(V_count), .SEL(SEL),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .FRAME_START(FRAME_START),
        .WR_REQ(WR_REQ), .WR_X(WR_X), .WR_Y(WR_Y), .WR_DATA(WR_DATA),
        .WR_ACK(WR_ACK), .WR_ERR(WR_ERR), .RAM_WE(RAM_WE),
        .RAM_WX(RAM_WX), .RAM_WY(RAM_WY), .RAM_WD(RAM_WD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model state: linear pixel position within the frame
    int   pos = 0;
    int   cyc = 0;
    bit   fs_exp = 1'b0;
    exp_t we_q[$];
    exp_t ack_q[$];
    bit   done = 1'b0;
    bit   frame_win = 1'b0;

    // Monitor-owned bookkeeping
    int   tests = 0;
    int   fails = 0;
    int   last_x = 0, last_y = 0, last_d = 0;
    bit   fw_active = 1'b0;
    int   hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, fw_h = -1, fw_v = -1;

    function automatic bit active(input int p);
        return ((p % H_L) < WID) && ((p / H_L) < HGT);
    endfunction

    // First cycle t >= c+2 where both t-1 and t are blanking, PIX_EN held high
    function automatic int write_cycle(input int c, input int p);
        for (int t = c + 2; t < c + 2 + 3 * N; t++) begin
            if (!active((p + t - c - 1) % N) && !active((p + t - c) % N)) return t;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos    <= 0;
            fs_exp <= 1'b0;
        end else begin
            fs_exp <= PIX_EN && (pos == N - 1);
            if (PIX_EN) pos <= (pos + 1) % N;
        end
    end

    // Monitor: raster outputs every cycle, scoreboard on RAM_WE / WR_ACK
    always @(negedge CLK) begin
        int   eh, ev;
        exp_t e;
        eh = pos % H_L;
        ev = pos / H_L;
        chk("h_count", int'(H_count), eh);
        chk("v_count", int'(V_count), ev);
        chk("sel", int'(SEL), int'(active(pos)));
        chk("hsync", int'(HSYNC), (eh >= HSS && eh < HSS + HSN) ? 0 : 1);
        chk("vsync", int'(VSYNC), (ev >= VSS && ev < VSS + VSN) ? 0 : 1);
        chk("frame_start", int'(FRAME_START), int'(fs_exp));

        if (RST) begin
            chk("rst_h_count", int'(H_count), 0);
            chk("rst_v_count", int'(V_count), 0);
            chk("rst_sel", int'(SEL), 1);
            chk("rst_hsync", int'(HSYNC), 1);
            chk("rst_vsync", int'(VSYNC), 1);
            chk("rst_frame_start", int'(FRAME_START), 0);
            chk("rst_wr_ack", int'(WR_ACK), 0);
            chk("rst_wr_err", int'(WR_ERR), 0);
            chk("rst_ram_we", int'(RAM_WE), 0);
            chk("rst_ram_wx", int'(RAM_WX), 0);
            chk("rst_ram_wy", int'(RAM_WY), 0);
            chk("rst_ram_wd", int'(RAM_WD), 0);
            last_x = 0;
            last_y = 0;
            last_d = 0;
        end

        if (RAM_WE) begin
            if (we_q.size() == 0) begin
                chk("unexpected_ram_we", int'(RAM_WE), 0);
            end else begin
                e = we_q.pop_front();
                chk("we_cycle", cyc, e.cyc);
                chk("ram_wx", int'(RAM_WX), e.x);
                chk("ram_wy", int'(RAM_WY), e.y);
                chk("ram_wd", int'(RAM_WD), e.d);
                chk("we_sel", int'(SEL), 0);
                last_x = e.x;
                last_y = e.y;
                last_d = e.d;
                $display("[TB] write x=%0d y=%0d d=%0d at cycle %0d", e.x, e.y, e.d, cyc);
            end
        end else begin
            if (!RST) begin
                chk("ram_wx_hold", int'(RAM_WX), last_x);
                chk("ram_wy_hold", int'(RAM_WY), last_y);
                chk("ram_wd_hold", int'(RAM_WD), last_d);
            end
            if (we_q.size() > 0 && we_q[0].cyc < cyc) begin
                chk("missing_ram_we", int'(RAM_WE), 1);
                void'(we_q.pop_front());
            end
        end

        if (WR_ACK) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_wr_ack", int'(WR_ACK), 0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("wr_err", int'(WR_ERR), e.err);
                $display("[TB] ack err=%0d at cycle %0d", int'(WR_ERR), cyc);
            end
        end else if (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            chk("missing_wr_ack", int'(WR_ACK), 1);
            void'(ack_q.pop_front());
        end

        if (frame_win) begin
            fw_active = 1'b1;
            if (!HSYNC) hs_cnt++;
            if (!VSYNC) vs_cnt++;
            if (FRAME_START) fs_cnt++;
            fw_h = int'(H_count);
            fw_v = int'(V_count);
        end else if (fw_active) begin
            fw_active = 1'b0;
            chk("frame_hsync_low_cycles", hs_cnt, V_L * HSN);
            chk("frame_vsync_low_cycles", vs_cnt, VSN * H_L);
            chk("frame_start_pulses", fs_cnt, 1);
            chk("frame_end_h", fw_h, 0);
            chk("frame_end_v", fw_v, 0);
        end

        if (done) begin
            chk("we_queue_empty", we_q.size(), 0);
            chk("ack_queue_empty", ack_q.size(), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!((pos % H_L) == h && (pos / H_L) == v) && n < 2 * N) begin
            step();
            n++;
        end
    endtask

    task automatic issue(input int x, input int y, input int d);
        WR_X    = HW'(x);
        WR_Y    = VW'(y);
        WR_DATA = 3'(d);
        WR_REQ  = 1'b1;
    endtask

    // Full handshake; PIX_EN is held high so the expected cycle is exact
    task automatic do_write(input int x, input int y, input int d);
        exp_t e;
        int   c, p, t, n;
        bit   got;
        c = cyc;
        p = pos;
        issue(x, y, d);
        if (BOUNDS_EN && (x >= WID || y >= HGT)) begin
            e = '{cyc: c + 2, x: x, y: y, d: d, err: 1};
            ack_q.push_back(e);
        end else begin
            t = write_cycle(c, p);
            e = '{cyc: t, x: x, y: y, d: d, err: 0};
            we_q.push_back(e);
            e.cyc = t + 1;
            ack_q.push_back(e);
        end
        n   = 0;
        got = 1'b0;
        while (!got && n < 2 * H_L + 10) begin
            step();
            n++;
            got = WR_ACK;
        end
        step();
        WR_REQ = 1'b0;
    endtask

    initial begin
        int x, y;
        RST = 1'b1; PIX_EN = 1'b0; WR_REQ = 1'b0;
        WR_X = '0; WR_Y = '0; WR_DATA = '0;
        repeat (3) step();
        RST = 1'b0;
        PIX_EN = 1'b1;

        // One full frame with the enable held high
        step();
        frame_win = 1'b1;
        repeat (N) step();
        frame_win = 1'b0;

        // Random pixel enable
        for (int i = 0; i < 300; i++) begin
            PIX_EN = 1'($urandom_range(0, 1));
            step();
        end
        PIX_EN = 1'b1;

        // Request in horizontal blanking: write two cycles later
        wait_pos(WID + 2, 10);
        do_write(5, 7, 5);
        // Request in the active region: deferred to blanking
        wait_pos(10, 10);
        do_write(9, 3, 2);
        // Column outside the active area
        wait_pos(WID + 1, 3);
        do_write(WID + 5, 4, 6);
        // Request across the last active line's wrap
        wait_pos(H_L - 3, HGT - 1);
        do_write(1, 2, 7);

        // Request withdrawn while waiting: no write, no ack
        wait_pos(2, 5);
        issue(3, 3, 3);
        step(); step();
        WR_REQ = 1'b0;
        repeat (H_L) step();

        // Reset while waiting
        wait_pos(2, 6);
        issue(4, 4, 4);
        step(); step();
        RST = 1'b1; WR_REQ = 1'b0;
        step(); step();
        RST = 1'b0;

        // Write something, then reset while in the write cycle
        wait_pos(WID + 2, 1);
        do_write(7, 6, 1);
        wait_pos(WID + 1, 2);
        issue(6, 6, 6);
        step(); step();
        RST = 1'b1; WR_REQ = 1'b0;
        step(); step();
        RST = 1'b0;

        // Randomised writes, mostly in range
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 60)) step();
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, H_L - 1))
                                             : int'($urandom_range(0, WID - 1));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V_L - 1))
                                             : int'($urandom_range(0, HGT - 1));
            do_write(x, y, int'($urandom_range(0, 7)));
        end

        repeat (H_L) step();
        done = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
